wait_for_transfer_multi: RTL and testbench

- Multi-channel successor of the single-channel wait-for-transfer custom instruction (CI).
- Each feature-transfer channel has a pending latch holding its last reported feature count, plus a saturating overrun counter.
- The CPU issues one CI to do one of four things on a selected channel: block on it with an optional timeout, poll it, read/clear its overruns, or flush it.
- Sits between the feature-extraction transfer engines (sys clock domain) and the CPU custom-instruction bus.

---
 rtl/wait_for_transfer_multi.sv | 207 ++++++++++++++++++++
 tb/tb_wait_for_transfer_multi.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/wait_for_transfer_multi.sv
// Multi-channel wait-for-transfer custom instruction: per-channel pending/count latches
// with saturating overrun counters, and a CI front end to wait on, poll, read or flush a channel.
module wft_chan #(
  parameter int COUNT_WIDTH   = 16,
  parameter int OVERRUN_WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     i_ready,
  input  logic [COUNT_WIDTH-1:0]   i_count,
  input  logic                     i_consume,
  input  logic                     i_ovr_clr,
  output logic                     o_pending,
  output logic [COUNT_WIDTH-1:0]   o_count,
  output logic [OVERRUN_WIDTH-1:0] o_ovr
);
  logic                     r_pending;
  logic [COUNT_WIDTH-1:0]   r_count;
  logic [OVERRUN_WIDTH-1:0] r_ovr;
  logic                     w_ovr_evt;

  // a consume in the same cycle as a new event takes the old value, so it is not an overrun
  assign w_ovr_evt = i_ready & r_pending & ~i_consume;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pending <= 1'b0;
      r_count   <= '0;
      r_ovr     <= '0;
    end else begin
      if (i_ready) begin
        r_count   <= i_count;
        r_pending <= 1'b1;
      end else if (i_consume) begin
        r_pending <= 1'b0;
      end
      if (i_ovr_clr)
        r_ovr <= w_ovr_evt ? OVERRUN_WIDTH'(1) : '0;
      else if (w_ovr_evt && r_ovr != '1)
        r_ovr <= r_ovr + 1'b1;
    end
  end

  assign o_pending = r_pending;
  assign o_count   = r_count;
  assign o_ovr     = r_ovr;
endmodule

module wait_for_transfer_multi #(
  parameter int CUSTOM_INSTRUCTION_ID = 42,
  parameter int NUM_CHANNELS          = 4,
  parameter int COUNT_WIDTH           = 16,
  parameter int OVERRUN_WIDTH         = 8
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [NUM_CHANNELS-1:0]             dataReady,
  input  logic [NUM_CHANNELS*COUNT_WIDTH-1:0] numberOfFeatures,
  input  logic                                ciStart,
  input  logic                                ciCke,
  input  logic [7:0]                          ciN,
  input  logic [31:0]                         ciValueA,
  input  logic [31:0]                         ciValueB,
  output logic [31:0]                         ciResult,
  output logic                                ciDone
);
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;
  localparam logic [1:0] OP_WAIT = 2'd0, OP_POLL = 2'd1, OP_ROVR = 2'd2, OP_FLUSH = 2'd3;

  state_t      r_state, w_state_n;
  logic [3:0]  r_ch, w_ch_n, w_ch;
  logic [23:0] r_tmo, w_tmo_n;
  logic        r_done, w_done_n;
  logic [31:0] r_result, w_result_n;

  logic [NUM_CHANNELS-1:0]                    w_pend, w_consume, w_ovr_clr;
  logic [NUM_CHANNELS-1:0][COUNT_WIDTH-1:0]   w_cnt;
  logic [NUM_CHANNELS-1:0][OVERRUN_WIDTH-1:0] w_ovr;

  logic                     w_acc, w_ch_ok, w_sel_pend, w_do_consume, w_do_ovr_clr;
  logic [COUNT_WIDTH-1:0]   w_sel_cnt;
  logic [OVERRUN_WIDTH-1:0] w_sel_ovr;
  logic                     w_unused;

  assign w_unused = ^{ciValueA[7:2], ciValueB[31:4]};

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_ch
    wft_chan #(.COUNT_WIDTH(COUNT_WIDTH), .OVERRUN_WIDTH(OVERRUN_WIDTH)) u_ch (
      .clock     (clock),
      .reset     (reset),
      .i_ready   (dataReady[k]),
      .i_count   (numberOfFeatures[k*COUNT_WIDTH +: COUNT_WIDTH]),
      .i_consume (w_consume[k]),
      .i_ovr_clr (w_ovr_clr[k]),
      .o_pending (w_pend[k]),
      .o_count   (w_cnt[k]),
      .o_ovr     (w_ovr[k])
    );
  end

  // the channel comes straight off the bus at accept, from the latched copy while waiting
  assign w_ch    = (r_state == S_IDLE) ? ciValueB[3:0] : r_ch;
  assign w_ch_ok = {1'b0, w_ch} < 5'(NUM_CHANNELS);
  assign w_acc   = ciStart & ciCke & (ciN == 8'(CUSTOM_INSTRUCTION_ID));

  always_comb begin
    w_sel_pend = 1'b0;
    w_sel_cnt  = '0;
    w_sel_ovr  = '0;
    w_consume  = '0;
    w_ovr_clr  = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (w_ch == 4'(k)) begin
        w_sel_pend   = w_pend[k];
        w_sel_cnt    = w_cnt[k];
        w_sel_ovr    = w_ovr[k];
        w_consume[k] = w_do_consume;
        w_ovr_clr[k] = w_do_ovr_clr;
      end
    end
  end

  always_comb begin
    w_state_n    = r_state;
    w_ch_n       = r_ch;
    w_tmo_n      = r_tmo;
    w_done_n     = 1'b0;
    w_result_n   = '0;
    w_do_consume = 1'b0;
    w_do_ovr_clr = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_acc) begin
          w_ch_n    = ciValueB[3:0];
          w_done_n  = 1'b1;
          w_state_n = S_RESP;
          if (!w_ch_ok) begin
            w_result_n = 32'h4000_0000;
          end else begin
            case (ciValueA[1:0])
              OP_WAIT: begin
                if (w_sel_pend) begin
                  w_result_n   = {2'b10, 30'(w_sel_cnt)};
                  w_do_consume = 1'b1;
                end else begin
                  w_done_n  = 1'b0;
                  w_tmo_n   = ciValueA[31:8];
                  w_state_n = S_WAIT;
                end
              end
              OP_POLL: begin
                if (w_sel_pend) w_result_n = {2'b10, 30'(w_sel_cnt)};
                w_do_consume = 1'b1;
              end
              OP_ROVR: begin
                w_result_n   = {2'b00, 30'(w_sel_ovr)};
                w_do_ovr_clr = 1'b1;
              end
              default: begin
                w_result_n   = 32'h8000_0000;
                w_do_consume = 1'b1;
                w_do_ovr_clr = 1'b1;
              end
            endcase
          end
        end
      end
      S_WAIT: begin
        // a zero timeout never decrements, so it waits until an event arrives
        if (ciCke) begin
          if (w_sel_pend) begin
            w_done_n     = 1'b1;
            w_result_n   = {2'b10, 30'(w_sel_cnt)};
            w_do_consume = 1'b1;
            w_state_n    = S_RESP;
          end else if (r_tmo != '0) begin
            w_tmo_n = r_tmo - 1'b1;
            if (r_tmo == 24'd1) begin
              w_done_n  = 1'b1;
              w_state_n = S_RESP;
            end
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_ch     <= '0;
      r_tmo    <= '0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_n;
      r_ch     <= w_ch_n;
      r_tmo    <= w_tmo_n;
      r_done   <= w_done_n;
      r_result <= w_result_n;
    end
  end

  assign ciDone   = r_done;
  assign ciResult = r_result;
endmodule

// File: tb/tb_wait_for_transfer_multi.sv
// Directed bench for wait_for_transfer_multi: latencies, results and overrun behaviour.
module tb_wait_for_transfer_multi;
  localparam int NC = 4, CW = 16;
  localparam logic [1:0] OP_WAIT = 2'd0, OP_POLL = 2'd1, OP_ROVR = 2'd2, OP_FLUSH = 2'd3;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [NC-1:0]      dataReady = '0;
  logic [NC*CW-1:0]   numberOfFeatures = '0;
  logic               ciStart = 1'b0, ciCke = 1'b1;
  logic [7:0]         ciN = 8'd42;
  logic [31:0]        ciValueA = '0, ciValueB = '0;
  logic [31:0]        ciResult;
  logic               ciDone;
  int                 n_run = 0, n_fail = 0, lat;

  wait_for_transfer_multi dut (
    .clock(clock), .reset(reset), .dataReady(dataReady), .numberOfFeatures(numberOfFeatures),
    .ciStart(ciStart), .ciCke(ciCke), .ciN(ciN), .ciValueA(ciValueA), .ciValueB(ciValueB),
    .ciResult(ciResult), .ciDone(ciDone)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clock); #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [3:0] ch, input logic [23:0] tmo);
    ciStart = 1'b1; ciCke = 1'b1; ciN = 8'd42;
    ciValueA = {tmo, 6'd0, op}; ciValueB = {28'd0, ch};
    step;
    ciStart = 1'b0; dataReady = '0;
  endtask

  task automatic ci_nb(input logic [1:0] op, input logic [3:0] ch, input logic [31:0] exp,
                       input string tag);
    issue(op, ch, 24'd0);
    chk({tag, "_done"}, 32'(ciDone), 32'd1);
    chk(tag, ciResult, exp);
    step;
  endtask

  task automatic ev(input int ch, input logic [CW-1:0] cnt);
    dataReady[ch] = 1'b1;
    numberOfFeatures[ch*CW +: CW] = cnt;
    step;
    dataReady = '0;
  endtask

  task automatic wait_done(input int start, output int l);
    l = start;
    while (!ciDone && l < 200) begin
      step;
      l++;
    end
  endtask

  initial begin
    step; step;
    chk("rst_done", 32'(ciDone), 32'd0);
    chk("rst_res", ciResult, 32'd0);
    reset = 1'b1;
    step;

    // poll: empty, hit, empty again
    ci_nb(OP_POLL, 4'd2, 32'h0, "poll_empty");
    ev(2, 16'd12);
    ci_nb(OP_POLL, 4'd2, 32'h8000_000C, "poll_hit");
    ci_nb(OP_POLL, 4'd2, 32'h0, "poll_again");

    // blocking wait, event 5 cycles after accept; a second ciStart while busy is ignored
    issue(OP_WAIT, 4'd1, 24'd0);
    chk("wait_busy", 32'(ciDone), 32'd0);
    ciStart = 1'b1; ciValueA = 32'd1; ciValueB = 32'd2;
    step;
    ciStart = 1'b0;
    chk("busy_ign", 32'(ciDone), 32'd0);
    step; step; step;
    dataReady[1] = 1'b1; numberOfFeatures[CW +: CW] = 16'd22;
    step;
    dataReady = '0;
    chk("wait_n1", 32'(ciDone), 32'd0);
    step;
    chk("wait_n2", 32'(ciDone), 32'd1);
    chk("wait_res", ciResult, 32'h8000_0016);
    step;
    ci_nb(OP_POLL, 4'd1, 32'h0, "wait_clr");

    // wait with event already pending completes one cycle after accept
    ev(0, 16'd3);
    ci_nb(OP_WAIT, 4'd0, 32'h8000_0003, "wait_fast");

    // timeout 10, then with three ciCke-low cycles mid-wait
    issue(OP_WAIT, 4'd0, 24'd10);
    wait_done(1, lat);
    chk("tmo_lat", 32'(lat), 32'd11);
    chk("tmo_res", ciResult, 32'h0);
    step;
    issue(OP_WAIT, 4'd0, 24'd10);
    step; step;
    ciCke = 1'b0;
    step; step; step;
    ciCke = 1'b1;
    wait_done(6, lat);
    chk("cke_lat", 32'(lat), 32'd14);
    step;

    // overruns and saturation
    ev(3, 16'd5); ev(3, 16'd6); ev(3, 16'd7);
    ci_nb(OP_POLL, 4'd3, 32'h8000_0007, "ovr_poll");
    ci_nb(OP_ROVR, 4'd3, 32'd2, "ovr_rd");
    ci_nb(OP_ROVR, 4'd3, 32'd0, "ovr_rd2");
    dataReady[3] = 1'b1;
    repeat (300) step;
    dataReady = '0;
    ci_nb(OP_ROVR, 4'd3, 32'd255, "ovr_sat");
    ci_nb(OP_FLUSH, 4'd3, 32'h8000_0000, "flush");
    ci_nb(OP_POLL, 4'd3, 32'h0, "flush_poll");
    ci_nb(OP_ROVR, 4'd3, 32'd0, "flush_ovr");

    // consume racing a new event: the event wins
    ev(3, 16'd17);
    dataReady[3] = 1'b1; numberOfFeatures[3*CW +: CW] = 16'd32;
    ci_nb(OP_POLL, 4'd3, 32'h8000_0011, "race_old");
    ci_nb(OP_POLL, 4'd3, 32'h8000_0020, "race_new");
    ci_nb(OP_ROVR, 4'd3, 32'd0, "race_ovr");
    ev(3, 16'd1); ev(3, 16'd2);
    dataReady[3] = 1'b1;
    ci_nb(OP_ROVR, 4'd3, 32'd1, "rd_race");
    ci_nb(OP_ROVR, 4'd3, 32'd1, "rd_race2");

    // out-of-range channel
    ci_nb(OP_POLL, 4'd9, 32'h4000_0000, "bad_ch");
    ci_nb(OP_WAIT, 4'd9, 32'h4000_0000, "bad_ch_wait");

    // reset mid-wait, then mid-response
    ev(2, 16'd5);
    issue(OP_WAIT, 4'd0, 24'd0);
    step;
    #2 reset = 1'b0;
    #1;
    chk("rstw_done", 32'(ciDone), 32'd0);
    chk("rstw_res", ciResult, 32'd0);
    step;
    reset = 1'b1;
    step;
    ci_nb(OP_POLL, 4'd2, 32'h0, "rst_pend");
    ev(1, 16'd9);
    issue(OP_POLL, 4'd1, 24'd0);
    chk("rstr_pre", ciResult, 32'h8000_0009);
    #2 reset = 1'b0;
    #1;
    chk("rstr_done", 32'(ciDone), 32'd0);
    chk("rstr_res", ciResult, 32'd0);
    step;
    reset = 1'b1;
    step;

    // foreign ciN is ignored
    ciStart = 1'b1; ciN = 8'd41; ciValueA = 32'd1; ciValueB = 32'd0;
    step;
    ciStart = 1'b0; ciN = 8'd42;
    chk("ciN41", 32'(ciDone), 32'd0);
    step;
    chk("ciN41_b", 32'(ciDone), 32'd0);
    ci_nb(OP_POLL, 4'd0, 32'h0, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
